// File: rtl/cpu_memsys_if.sv
// cpu_memsys_if: CPU-side bus bundle for cpu_memsys.
//   Fetch  : IA (addr) -> ID (instruction)
//   Data   : DA, RW, DREQ -> DRDY (the DD data bus is a plain inout on the top)
//   Preload: LDEN, LDSEL, LDA, LDD
//   Status : PASS
// The CPU/bench side uses the master modport and the memory uses the slave modport.
interface cpu_memsys_if #(
   parameter int W  = 16,
   parameter int AW = 7
);
   logic [AW-1:0] IA;
   logic [W-1:0]  ID;
   logic [AW-1:0] DA;
   logic          RW;
   logic          DREQ;
   logic          DRDY;
   logic          LDEN;
   logic          LDSEL;
   logic [AW-1:0] LDA;
   logic [W-1:0]  LDD;
   logic          PASS;

   modport master (output IA, DA, RW, DREQ, LDEN, LDSEL, LDA, LDD,
                   input  ID, DRDY, PASS);
   modport slave  (input  IA, DA, RW, DREQ, LDEN, LDSEL, LDA, LDD,
                   output ID, DRDY, PASS);
endinterface

// File: rtl/cpu_memsys.sv
// cpu_memsys: instruction and data memories for the 16-bit CPU.
// All state changes on the falling edge of CK. RST is an active-low asynchronous reset.
//   CK, RST : clock and reset
//   DD      : bidirectional data bus. The memory drives it whenever RW=1.
//   bus     : fetch, data handshake, preload and pass-flag signals (slave modport)
//
// state  | meaning
// S_IDLE | ready for a request; a LAT=0 access completes at acceptance
// S_WAIT | counting wait states, or holding an access deferred by a DMEM preload
// S_ACK  | access done; DRDY high for this one cycle
module cpu_memsys #(
   parameter int W         = 16,
   parameter int AW        = 7,
   parameter int LAT       = 0,
   parameter int PASS_ADDR = 0,
   parameter int PASS_VAL  = 4
) (
   input  logic         CK,
   input  logic         RST,
   inout  wire [W-1:0]  DD,
   cpu_memsys_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] da_q, da_d;
   logic          rw_q, rw_d;
   logic [W-1:0]  wd_q, wd_d;
   logic [W-1:0]  rdq_q, rdq_d;
   logic [W-1:0]  id_q, id_d;
   logic          pass_q, pass_d;

   logic [W-1:0]  imem_q [2**AW];
   logic [W-1:0]  dmem_q [2**AW];

   logic          dmem_pl, do_acc, do_wr;
   logic [AW-1:0] acc_da;
   logic          acc_rw;
   logic [W-1:0]  acc_wd;

   assign DD       = bus.RW ? rdq_q : 'z;
   assign bus.ID   = id_q;
   assign bus.DRDY = (state_q == S_ACK);
   assign bus.PASS = pass_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      da_d    = da_q;
      rw_d    = rw_q;
      wd_d    = wd_q;
      do_acc  = 1'b0;
      acc_da  = da_q;
      acc_rw  = rw_q;
      acc_wd  = wd_q;
      dmem_pl = bus.LDEN & bus.LDSEL;

      case (state_q)
         S_IDLE: begin
            if (bus.DREQ) begin
               da_d   = bus.DA;
               rw_d   = bus.RW;
               wd_d   = DD;
               cnt_d  = LAT_C;
               // A zero-latency access uses the live inputs, since they are only now being latched.
               acc_da = bus.DA;
               acc_rw = bus.RW;
               acc_wd = DD;
               if (LAT_C != 4'd0) begin
                  state_d = S_WAIT;
               end else if (dmem_pl) begin
                  state_d = S_WAIT;
               end else begin
                  do_acc  = 1'b1;
                  state_d = S_ACK;
               end
            end
         end
         S_WAIT: begin
            // Terminal count is 1 (normal path) or 0 (an access deferred by a preload).
            if (cnt_q <= 4'd1) begin
               cnt_d = 4'd0;
               if (!dmem_pl) begin
                  do_acc  = 1'b1;
                  state_d = S_ACK;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      rdq_d = rdq_q;
      if (do_acc && acc_rw) rdq_d = dmem_q[acc_da];
      // Gating with RST means a request held during reset can never write DMEM.
      do_wr  = do_acc & ~acc_rw & RST;
      pass_d = pass_q | (do_wr && (acc_da == AW'(PASS_ADDR)) && (acc_wd == W'(PASS_VAL)));
      id_d   = imem_q[bus.IA];
   end

   always_ff @(negedge CK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         da_q    <= '0;
         rw_q    <= 1'b0;
         wd_q    <= '0;
         rdq_q   <= '0;
         id_q    <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         da_q    <= da_d;
         rw_q    <= rw_d;
         wd_q    <= wd_d;
         rdq_q   <= rdq_d;
         id_q    <= id_d;
         pass_q  <= pass_d;
      end
   end

   // The memories have no reset. Nonblocking writes make a same-edge read return the old word.
   always_ff @(negedge CK) begin
      if (bus.LDEN && !bus.LDSEL) imem_q[bus.LDA] <= bus.LDD;
   end

   always_ff @(negedge CK) begin
      if (dmem_pl)    dmem_q[bus.LDA] <= bus.LDD;
      else if (do_wr) dmem_q[acc_da]  <= acc_wd;
   end
endmodule

// File: tb/tb_cpu_memsys.sv
module tb_cpu_memsys;
   logic clk = 1'b1;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   cpu_memsys_if #(.W(16), .AW(7)) b0 ();
   cpu_memsys_if #(.W(16), .AW(7)) b3 ();
   cpu_memsys_if #(.W(16), .AW(7)) b2 ();

   wire  [15:0] dd0, dd3, dd2;
   logic [15:0] drv0, drv3, drv2;
   assign dd0 = b0.RW ? 16'bz : drv0;
   assign dd3 = b3.RW ? 16'bz : drv3;
   assign dd2 = b2.RW ? 16'bz : drv2;

   cpu_memsys #(.LAT(0)) u0 (.CK(clk), .RST(rst_n), .DD(dd0), .bus(b0.slave));
   cpu_memsys #(.LAT(3)) u3 (.CK(clk), .RST(rst_n), .DD(dd3), .bus(b3.slave));
   cpu_memsys #(.LAT(2)) u2 (.CK(clk), .RST(rst_n), .DD(dd2), .bus(b2.slave));

   // Advance past one falling (active) edge and stop at the following rising edge.
   task automatic tick();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      b0.IA = '0; b0.DA = '0; b0.RW = 1'b0; b0.DREQ = 1'b0;
      b0.LDEN = 1'b0; b0.LDSEL = 1'b0; b0.LDA = '0; b0.LDD = '0;
      b3.IA = '0; b3.DA = '0; b3.RW = 1'b0; b3.DREQ = 1'b0;
      b3.LDEN = 1'b0; b3.LDSEL = 1'b0; b3.LDA = '0; b3.LDD = '0;
      b2.IA = '0; b2.DA = '0; b2.RW = 1'b0; b2.DREQ = 1'b0;
      b2.LDEN = 1'b0; b2.LDSEL = 1'b0; b2.LDA = '0; b2.LDD = '0;
      drv0 = 16'h5A5A; drv3 = '0; drv2 = '0;
      tick(); tick();
      n_cmp++; if (b0.ID !== 16'h0) begin n_bad++; $display("FAIL rst_id: got %h want 0000", b0.ID); end
      n_cmp++; if (b0.DRDY !== 1'b0) begin n_bad++; $display("FAIL rst_drdy: got %b want 0", b0.DRDY); end
      n_cmp++; if (b0.PASS !== 1'b0) begin n_bad++; $display("FAIL rst_pass: got %b want 0", b0.PASS); end
      n_cmp++; if (dd0 !== 16'h5A5A) begin n_bad++; $display("FAIL rst_dd_released: got %h want 5a5a", dd0); end
      b0.RW = 1'b1;
      #1;
      n_cmp++; if (dd0 !== 16'h0) begin n_bad++; $display("FAIL rst_dd_rdq: got %h want 0000", dd0); end
      b0.RW = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pass_preload();
      b3.LDEN = 1'b1; b3.LDSEL = 1'b1; b3.LDA = 7'd0; b3.LDD = 16'd4;
      tick();
      b3.LDEN = 1'b0;
      n_cmp++; if (u3.dmem_q[0] !== 16'd4) begin n_bad++; $display("FAIL pl_dmem0: got %h want 0004", u3.dmem_q[0]); end
      n_cmp++; if (b3.PASS !== 1'b0) begin n_bad++; $display("FAIL pl_pass: got %b want 0", b3.PASS); end
   endtask

   task automatic test_fetch();
      b0.LDEN = 1'b1; b0.LDSEL = 1'b0; b0.LDA = 7'd3; b0.LDD = 16'hC100;
      tick();
      b0.LDEN = 1'b0; b0.IA = 7'd3;
      tick();
      n_cmp++; if (b0.ID !== 16'hC100) begin n_bad++; $display("FAIL fetch: got %h want c100", b0.ID); end
      b0.LDEN = 1'b1; b0.LDA = 7'd3; b0.LDD = 16'h1234;
      tick();
      b0.LDEN = 1'b0;
      n_cmp++; if (b0.ID !== 16'hC100) begin n_bad++; $display("FAIL fetch_rbw: got %h want c100", b0.ID); end
      tick();
      n_cmp++; if (b0.ID !== 16'h1234) begin n_bad++; $display("FAIL fetch_new: got %h want 1234", b0.ID); end
   endtask

   task automatic test_read_lat0();
      b0.LDEN = 1'b1; b0.LDSEL = 1'b1; b0.LDA = 7'd1; b0.LDD = 16'd50;
      tick();
      b0.LDEN = 1'b0;
      b0.DREQ = 1'b1; b0.RW = 1'b1; b0.DA = 7'd1;
      #1;
      n_cmp++; if (b0.DRDY !== 1'b0) begin n_bad++; $display("FAIL r0_pre_drdy: got %b want 0", b0.DRDY); end
      tick();
      b0.DREQ = 1'b0;
      n_cmp++; if (dd0 !== 16'd50) begin n_bad++; $display("FAIL r0_data: got %0d want 50", dd0); end
      n_cmp++; if (b0.DRDY !== 1'b1) begin n_bad++; $display("FAIL r0_drdy: got %b want 1", b0.DRDY); end
      tick();
      n_cmp++; if (b0.DRDY !== 1'b0) begin n_bad++; $display("FAIL r0_drdy_end: got %b want 0", b0.DRDY); end
      n_cmp++; if (dd0 !== 16'd50) begin n_bad++; $display("FAIL r0_data_hold: got %0d want 50", dd0); end
      b0.RW = 1'b0; drv0 = 16'h0C0D;
      #1;
      n_cmp++; if (dd0 !== 16'h0C0D) begin n_bad++; $display("FAIL r0_bus_release: got %h want 0c0d", dd0); end
   endtask

   task automatic test_pass_detect();
      b0.DA = 7'd0; b0.RW = 1'b0; drv0 = 16'd4; b0.DREQ = 1'b1;
      tick();
      b0.DREQ = 1'b0;
      n_cmp++; if (b0.DRDY !== 1'b1) begin n_bad++; $display("FAIL pass_w_drdy: got %b want 1", b0.DRDY); end
      n_cmp++; if (b0.PASS !== 1'b1) begin n_bad++; $display("FAIL pass_set: got %b want 1", b0.PASS); end
      tick();
      drv0 = 16'd5; b0.DREQ = 1'b1;
      tick();
      b0.DREQ = 1'b0;
      n_cmp++; if (u0.dmem_q[0] !== 16'd5) begin n_bad++; $display("FAIL pass_w5: got %h want 0005", u0.dmem_q[0]); end
      n_cmp++; if (b0.PASS !== 1'b1) begin n_bad++; $display("FAIL pass_sticky: got %b want 1", b0.PASS); end
      tick();
   endtask

   task automatic test_write_lat3();
      b3.LDEN = 1'b1; b3.LDSEL = 1'b1; b3.LDA = 7'd2; b3.LDD = 16'h0099;
      tick();
      b3.LDA = 7'd9; b3.LDD = 16'h0011;
      tick();
      b3.LDEN = 1'b0;
      b3.DREQ = 1'b1; b3.RW = 1'b0; b3.DA = 7'd2; drv3 = 16'd7;
      tick();
      // Changes after acceptance must be ignored.
      b3.DREQ = 1'b0; b3.DA = 7'd9; drv3 = 16'd3;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (b3.DRDY !== 1'b0) begin n_bad++; $display("FAIL w3_drdy_early k=%0d: got %b want 0", k, b3.DRDY); end
         n_cmp++; if (u3.dmem_q[2] !== 16'h0099) begin n_bad++; $display("FAIL w3_mem_early k=%0d: got %h want 0099", k, u3.dmem_q[2]); end
         if (k < 2) tick();
      end
      tick();
      n_cmp++; if (b3.DRDY !== 1'b1) begin n_bad++; $display("FAIL w3_drdy: got %b want 1", b3.DRDY); end
      n_cmp++; if (u3.dmem_q[2] !== 16'd7) begin n_bad++; $display("FAIL w3_mem: got %h want 0007", u3.dmem_q[2]); end
      n_cmp++; if (u3.dmem_q[9] !== 16'h0011) begin n_bad++; $display("FAIL w3_mem9: got %h want 0011", u3.dmem_q[9]); end
      tick();
      n_cmp++; if (b3.DRDY !== 1'b0) begin n_bad++; $display("FAIL w3_drdy_end: got %b want 0", b3.DRDY); end
      b3.DREQ = 1'b1; b3.RW = 1'b1; b3.DA = 7'd2;
      tick();
      b3.DREQ = 1'b0;
      tick(); tick();
      n_cmp++; if (b3.DRDY !== 1'b0) begin n_bad++; $display("FAIL r3_drdy_early: got %b want 0", b3.DRDY); end
      tick();
      n_cmp++; if (b3.DRDY !== 1'b1) begin n_bad++; $display("FAIL r3_drdy: got %b want 1", b3.DRDY); end
      n_cmp++; if (dd3 !== 16'd7) begin n_bad++; $display("FAIL r3_data: got %0d want 7", dd3); end
      tick();
   endtask

   task automatic test_collision();
      b2.LDEN = 1'b1; b2.LDSEL = 1'b1; b2.LDA = 7'd5; b2.LDD = 16'h0000;
      tick();
      b2.LDEN = 1'b0;
      b2.DREQ = 1'b1; b2.RW = 1'b0; b2.DA = 7'd5; drv2 = 16'h00AB;
      tick();
      b2.DREQ = 1'b0;
      tick();
      b2.LDEN = 1'b1; b2.LDSEL = 1'b1; b2.LDA = 7'd5; b2.LDD = 16'h0066;
      tick();
      b2.LDEN = 1'b0;
      n_cmp++; if (b2.DRDY !== 1'b0) begin n_bad++; $display("FAIL col_drdy_deferred: got %b want 0", b2.DRDY); end
      n_cmp++; if (u2.dmem_q[5] !== 16'h0066) begin n_bad++; $display("FAIL col_preload_wins: got %h want 0066", u2.dmem_q[5]); end
      tick();
      n_cmp++; if (b2.DRDY !== 1'b1) begin n_bad++; $display("FAIL col_drdy: got %b want 1", b2.DRDY); end
      n_cmp++; if (u2.dmem_q[5] !== 16'h00AB) begin n_bad++; $display("FAIL col_mem: got %h want 00ab", u2.dmem_q[5]); end
      tick();
      n_cmp++; if (b2.DRDY !== 1'b0) begin n_bad++; $display("FAIL col_drdy_end: got %b want 0", b2.DRDY); end
   endtask

   task automatic test_reset_mid();
      b2.DREQ = 1'b1; b2.RW = 1'b0; b2.DA = 7'd5; drv2 = 16'h0EEE;
      tick();
      b2.DREQ = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (b0.PASS !== 1'b0) begin n_bad++; $display("FAIL rm_pass_async: got %b want 0", b0.PASS); end
      for (int k = 0; k < 2; k++) begin
         tick();
         n_cmp++; if (b2.DRDY !== 1'b0) begin n_bad++; $display("FAIL rm_drdy k=%0d: got %b want 0", k, b2.DRDY); end
         n_cmp++; if (u2.dmem_q[5] !== 16'h00AB) begin n_bad++; $display("FAIL rm_mem k=%0d: got %h want 00ab", k, u2.dmem_q[5]); end
      end
      rst_n = 1'b1;
      tick();
      n_cmp++; if (u2.dmem_q[5] !== 16'h00AB) begin n_bad++; $display("FAIL rm_mem_after: got %h want 00ab", u2.dmem_q[5]); end
      b2.DREQ = 1'b1; b2.RW = 1'b1; b2.DA = 7'd5;
      tick();
      b2.DREQ = 1'b0;
      tick();
      n_cmp++; if (b2.DRDY !== 1'b0) begin n_bad++; $display("FAIL rm_rd_drdy_early: got %b want 0", b2.DRDY); end
      tick();
      n_cmp++; if (b2.DRDY !== 1'b1) begin n_bad++; $display("FAIL rm_rd_drdy: got %b want 1", b2.DRDY); end
      n_cmp++; if (dd2 !== 16'h00AB) begin n_bad++; $display("FAIL rm_rd_data: got %h want 00ab", dd2); end
      tick();
   endtask

   initial begin
      test_reset();
      test_pass_preload();
      test_fetch();
      test_read_lat0();
      test_pass_detect();
      test_write_lat3();
      test_collision();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
